// File: rtl/bit_multiplier_n.sv
`default_nettype none
// ============================================================================
// Module      : bit_multiplier_n
// Description : Signed (two's complement) shift-add multiplier. Forms S * B
//               in W add/shift iterations into {A,B}, with X as the sign
//               extension of A. Operand S is latched at start; Busy/Done
//               report progress.
//               Optional overflow flag (Ovf) is built when the macro
//               MULT_OVF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_multiplier_n #(
  parameter int W = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         ClearA_LoadB,
  input  logic         Run,
  input  logic [W-1:0] S,
  output logic [W-1:0] Aval,
  output logic [W-1:0] Bval,
  output logic         X,
  output logic         Busy,
  output logic         Done
`ifdef MULT_OVF_EN
  ,
  output logic         Ovf
`endif
);

  localparam int              c_CW   = $clog2(W);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(W - 1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_ADD   = 2'd1;
  localparam logic [1:0] c_SHIFT = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  logic [1:0]      r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_s;
  logic            r_x;
  logic            r_run_q;
  logic [c_CW-1:0] r_cnt;

  logic            w_run_rise;
  logic [W:0]      w_acc_a;
  logic [W:0]      w_acc_s;
  logic [W:0]      w_sum;
  logic [W-1:0]    w_sh_a;
  logic [W-1:0]    w_sh_b;

  assign w_run_rise = Run & ~r_run_q;

  // The last partial product weighs the sign bit of B, so it is subtracted.
  assign w_acc_a = {r_a[W-1], r_a};
  assign w_acc_s = {r_s[W-1], r_s};
  assign w_sum   = (r_cnt == c_LAST) ? (w_acc_a - w_acc_s) : (w_acc_a + w_acc_s);

  // Arithmetic right shift of {X,A,B}; X is the replicated sign.
  assign w_sh_a = {r_x, r_a[W-1:1]};
  assign w_sh_b = {r_a[0], r_b[W-1:1]};

  // Run level history for edge detection, tracked in every state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_run_q <= 1'b0;
    end else begin
      r_run_q <= Run;
    end
  end

  // Control FSM and datapath registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= c_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_x     <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (ClearA_LoadB) begin
            // Load wins over a coincident start; that start is dropped.
            r_a <= '0;
            r_x <= 1'b0;
            r_b <= S;
          end else if (w_run_rise) begin
            // B is kept, so back-to-back runs chain on the previous low half.
            r_s     <= S;
            r_a     <= '0;
            r_x     <= 1'b0;
            r_cnt   <= '0;
            r_state <= c_ADD;
          end
        end
        c_ADD: begin
          if (r_b[0]) begin
            r_x <= w_sum[W];
            r_a <= w_sum[W-1:0];
          end
          r_state <= c_SHIFT;
        end
        c_SHIFT: begin
          r_a   <= w_sh_a;
          r_b   <= w_sh_b;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_LAST) begin
            r_state <= c_DONE;
          end else begin
            r_state <= c_ADD;
          end
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

`ifdef MULT_OVF_EN
  logic r_ovf;
  logic w_ovf_now;

  // Product fits in W signed bits only if {X,A} is all copies of B's sign.
  assign w_ovf_now = ({r_x, w_sh_a} != {(W + 1){w_sh_b[W-1]}});

  // Overflow flag: settled on the final shift, cleared by load or start.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_ovf <= 1'b0;
    end else if ((r_state == c_IDLE) && (ClearA_LoadB || w_run_rise)) begin
      r_ovf <= 1'b0;
    end else if ((r_state == c_SHIFT) && (r_cnt == c_LAST)) begin
      r_ovf <= w_ovf_now;
    end
  end

  assign Ovf = r_ovf;
`endif

  assign Aval = r_a;
  assign Bval = r_b;
  assign X    = r_x;
  assign Busy = (r_state == c_ADD) || (r_state == c_SHIFT);
  assign Done = (r_state == c_DONE);

endmodule
`default_nettype wire

// File: tb/tb_bit_multiplier_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_bit_multiplier_n
// Description : Self-checking bench for bit_multiplier_n (W = 8). Expected
//               results come from integer multiplication of the signed
//               operands; B is tracked across runs for chained multiplies.
//               Ovf is checked when MULT_OVF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_multiplier_n;

  localparam int W = 8;

  logic         Clk = 1'b0;
  logic         Reset;
  logic         ClearA_LoadB;
  logic         Run;
  logic [W-1:0] S;
  logic [W-1:0] Aval;
  logic [W-1:0] Bval;
  logic         X;
  logic         Busy;
  logic         Done;
`ifdef MULT_OVF_EN
  logic         Ovf;
`endif

  int checks = 0;
  int errors = 0;

  // Reference view of the multiplier register B and of the overflow flag.
  logic [W-1:0] m_b;
  logic         m_ovf;

  bit_multiplier_n #(.W(W)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .ClearA_LoadB (ClearA_LoadB),
    .Run          (Run),
    .S            (S),
    .Aval         (Aval),
    .Bval         (Bval),
    .X            (X),
    .Busy         (Busy),
    .Done         (Done)
`ifdef MULT_OVF_EN
    ,
    .Ovf          (Ovf)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_ovf(input string tag);
`ifdef MULT_OVF_EN
    check(tag, Ovf, m_ovf);
`endif
  endtask

  task automatic do_load(input logic [W-1:0] b);
    S            = b;
    ClearA_LoadB = 1'b1;
    tick();
    ClearA_LoadB = 1'b0;
    m_b   = b;
    m_ovf = 1'b0;
    check("load_A", Aval, 0);
    check("load_B", Bval, b);
    check("load_X", X, 0);
    check("load_busy", Busy, 0);
    check_ovf("load_ovf");
  endtask

  // One multiply of s by the current B; hold keeps Run high, poke pulses
  // ClearA_LoadB mid-operation. S is scrambled while busy.
  task automatic do_mult(input logic [W-1:0] s, input bit hold, input bit poke);
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    longint              p;
    logic [2*W-1:0]      pw;
    int                  n;
    bit                  seen;
    sa   = s;
    sb   = m_b;
    p    = longint'(sa) * longint'(sb);
    pw   = p[2*W-1:0];
    S    = s;
    Run  = 1'b1;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 4 * W + 8) begin
      tick();
      n++;
      if (!hold) Run = 1'b0;
      S            = W'($urandom);
      ClearA_LoadB = poke && (n == 3 || n == 4);
      if (Done) seen = 1'b1;
      else check("busy_during_op", Busy, 1);
    end
    ClearA_LoadB = 1'b0;
    check("done_latency", n, 2 * W + 1);
    check("prod_A", Aval, pw[2*W-1:W]);
    check("prod_B", Bval, pw[W-1:0]);
    check("prod_X", X, pw[2*W-1]);
    check("busy_at_done", Busy, 0);
    m_b   = pw[W-1:0];
    m_ovf = (p < -(longint'(1) << (W - 1))) || (p > ((longint'(1) << (W - 1)) - 1));
    check_ovf("prod_ovf");
    tick();
    check("done_pulse", Done, 0);
  endtask

  initial begin
    int dones;
    Reset        = 1'b1;
    ClearA_LoadB = 1'b0;
    Run          = 1'b0;
    S            = '0;
    m_b          = '0;
    m_ovf        = 1'b0;
    tick();
    tick();
    check("rst_A", Aval, 0);
    check("rst_B", Bval, 0);
    check("rst_X", X, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check_ovf("rst_ovf");
    Reset = 1'b0;
    tick();

    // Directed products, including the most negative operands.
    do_load(8'hF0);
    do_mult(8'h40, 1'b0, 1'b0);
    check("t1_A", Aval, 8'hFC);
    check("t1_B", Bval, 8'h00);
    do_load(8'hC5);
    do_mult(8'h07, 1'b0, 1'b0);
    do_load(8'h80);
    do_mult(8'h80, 1'b0, 1'b0);
    check("t3_A", Aval, 8'h40);
    do_load(8'h02);
    do_mult(8'h03, 1'b0, 1'b0);
    do_mult(8'h03, 1'b0, 1'b0);
    check("t4_chain_B", Bval, 8'h12);

    // Run held high: one multiply only, and a mid-op load pulse is ignored.
    do_load(8'h7F);
    do_mult(8'h81, 1'b1, 1'b1);
    dones = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (Done || Busy) dones++;
    end
    check("run_held_no_retrigger", dones, 0);
    Run = 1'b0;
    tick();

    // Reset in the middle of an operation.
    S   = 8'h55;
    Run = 1'b1;
    tick();
    Run = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    m_b   = '0;
    m_ovf = 1'b0;
    check("midrst_A", Aval, 0);
    check("midrst_B", Bval, 0);
    check("midrst_X", X, 0);
    check("midrst_busy", Busy, 0);
    check("midrst_done", Done, 0);
    check_ovf("midrst_ovf");
    tick();
    check("midrst_idle", Busy, 0);

    // Load and Run together: load only.
    S            = 8'h5A;
    ClearA_LoadB = 1'b1;
    Run          = 1'b1;
    tick();
    ClearA_LoadB = 1'b0;
    m_b          = 8'h5A;
    check("coinc_B", Bval, 8'h5A);
    check("coinc_busy", Busy, 0);
    tick();
    check("coinc_no_start", Busy, 0);
    Run = 1'b0;
    tick();

    // Random loads and chained runs.
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 2) != 0) do_load(W'($urandom));
      do_mult(W'($urandom), 1'b0, (i % 5) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
